// File: rtl/md_ctrl_pkg.sv
// Shared definitions for the execute-stage multiply/divide controller:
// E-stage HI/LO op encodings, datapath op codes, FSM states and decode helpers.
package md_ctrl_pkg;

  // E-stage HI/LO-class op encodings shared with the decoder
  localparam logic [3:0] HILO_NONE  = 4'd0;
  localparam logic [3:0] HILO_MULT  = 4'd1;
  localparam logic [3:0] HILO_MULTU = 4'd2;
  localparam logic [3:0] HILO_DIV   = 4'd3;
  localparam logic [3:0] HILO_DIVU  = 4'd4;
  localparam logic [3:0] HILO_MFHI  = 4'd5;
  localparam logic [3:0] HILO_MFLO  = 4'd6;
  localparam logic [3:0] HILO_MTHI  = 4'd7;
  localparam logic [3:0] HILO_MTLO  = 4'd8;

  // Datapath op codes; MULT is zero so an idle dp_op bus reads as 0
  localparam logic [1:0] MD_OP_MULT  = 2'd0;
  localparam logic [1:0] MD_OP_MULTU = 2'd1;
  localparam logic [1:0] MD_OP_DIV   = 2'd2;
  localparam logic [1:0] MD_OP_DIVU  = 2'd3;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  // True for ops that occupy the multi-cycle datapath
  function automatic logic is_start_op(input logic [3:0] op);
    return (op == HILO_MULT) || (op == HILO_MULTU) ||
           (op == HILO_DIV)  || (op == HILO_DIVU);
  endfunction

  // True for the two divide ops
  function automatic logic is_div_op(input logic [3:0] op);
    return (op == HILO_DIV) || (op == HILO_DIVU);
  endfunction

  // Map an E-stage start op onto the datapath op code
  function automatic logic [1:0] md_op_of(input logic [3:0] op);
    logic [1:0] code;
    case (op)
      HILO_MULT:  code = MD_OP_MULT;
      HILO_MULTU: code = MD_OP_MULTU;
      HILO_DIV:   code = MD_OP_DIV;
      HILO_DIVU:  code = MD_OP_DIVU;
      default:    code = 2'd0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/md_ctrl_chk.sv
// Simulation-only protocol checker for md_ctrl: a start op must never be
// presented while the datapath is busy, and the pending op code must hold
// steady while a multiply/divide is in flight.
module md_ctrl_chk
  import md_ctrl_pkg::*;
(
  input logic       clk,
  input logic       reset,
  input logic       run,
  input logic       op_valid,
  input logic       start_op,
  input logic       dp_done,
  input logic [1:0] pend_op
);

  logic       hold_r;
  logic [1:0] pend_prev_r;

  // Remember whether the previous cycle was a non-completing RUN cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_r      <= 1'b0;
      pend_prev_r <= 2'd0;
    end else begin
      hold_r      <= run & ~dp_done;
      pend_prev_r <= pend_op;
    end
  end

  // Flag a start op issued into a busy controller and any pending-op corruption
  always @(posedge clk) begin
    if (reset) begin
      a_no_start_in_run: assert (!(run && op_valid && start_op));
      a_pend_stable: assert (!hold_r || (pend_op == pend_prev_r));
    end
  end

endmodule

// File: rtl/md_ctrl.sv
// Execute-stage multiply/divide controller. Owns the architectural HI/LO
// registers, issues mult/multu/div/divu to an external datapath with a
// start/done handshake, serves mfhi/mflo/mthi/mtlo and raises HILObusy.
// Optional build macro MD_CTRL_DIV0_FAST_EN: a divide by zero is resolved
// locally (HI=RD1, LO=all ones) instead of being sent to the datapath.
module md_ctrl
  import md_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        op_valid,
  input  logic [3:0]  HILOOp,
  input  logic [31:0] RD1,
  input  logic [31:0] RD2,
  output logic        HILObusy,
  output logic [31:0] HILOout,
  output logic        dp_start,
  output logic [1:0]  dp_op,
  output logic [31:0] dp_a,
  output logic [31:0] dp_b,
  input  logic        dp_done,
  input  logic [31:0] dp_hi,
  input  logic [31:0] dp_lo
);

  md_state_e   state_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic [1:0]  pend_op_r;

  logic accept_s;
  logic start_op_s;
  logic div0_s;
  logic issue_s;

  // Only an unflushed, valid op in IDLE is acted on; Req squashes it
  assign accept_s   = op_valid & ~Req & (state_r == MD_IDLE);
  assign start_op_s = is_start_op(HILOOp);

`ifdef MD_CTRL_DIV0_FAST_EN
  assign div0_s = accept_s & is_div_op(HILOOp) & (RD2 == 32'h0000_0000);
`else
  assign div0_s = 1'b0;
`endif

  assign issue_s = accept_s & start_op_s & ~div0_s;

  // Datapath issue bus, stall request and mfhi/mflo read port
  always_comb begin
    dp_start = issue_s;
    HILObusy = issue_s | div0_s | (state_r == MD_RUN);
    if (issue_s) begin
      dp_op = md_op_of(HILOOp);
      dp_a  = RD1;
      dp_b  = RD2;
    end else begin
      dp_op = 2'd0;
      dp_a  = 32'h0000_0000;
      dp_b  = 32'h0000_0000;
    end
    case (HILOOp)
      HILO_MFHI: HILOout = hi_r;
      HILO_MFLO: HILOout = lo_r;
      default:   HILOout = 32'h0000_0000;
    endcase
  end

  // Controller FSM and HI/LO architectural state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= MD_IDLE;
      hi_r      <= 32'h0000_0000;
      lo_r      <= 32'h0000_0000;
      pend_op_r <= 2'd0;
    end else begin
      case (state_r)
        MD_IDLE: begin
          if (accept_s) begin
            case (HILOOp)
              HILO_MULT, HILO_MULTU, HILO_DIV, HILO_DIVU: begin
                if (div0_s) begin
                  hi_r <= RD1;
                  lo_r <= 32'hFFFF_FFFF;
                end else begin
                  state_r   <= MD_RUN;
                  pend_op_r <= md_op_of(HILOOp);
                end
              end
              HILO_MTHI: hi_r <= RD1;
              HILO_MTLO: lo_r <= RD1;
              default: ;
            endcase
          end
        end
        MD_RUN: begin
          // Req is ignored here: the in-flight op is older than any fault
          if (dp_done) begin
            hi_r    <= dp_hi;
            lo_r    <= dp_lo;
            state_r <= MD_IDLE;
          end
        end
        default: state_r <= MD_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  md_ctrl_chk u_chk (
    .clk      (clk),
    .reset    (reset),
    .run      (state_r == MD_RUN),
    .op_valid (op_valid),
    .start_op (start_op_s),
    .dp_done  (dp_done),
    .pend_op  (pend_op_r)
  );
`endif

endmodule

// File: doc/md_ctrl.md
# md_ctrl

Execute-stage controller that sequences a separate multi-cycle multiply/divide datapath and owns the architectural HI/LO registers. It decodes the E-stage `HILOOp`, issues operands to the datapath with a start/done handshake, commits results to HI/LO, serves mfhi/mflo/mthi/mtlo, and raises `HILObusy` so the pipeline stall unit holds younger HI/LO-class instructions. It sits between the E-stage register and the arithmetic datapath, beside the ALU.

## Interface
- No parameters. `HILOOp` uses the shared `HILO_*` encodings.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `Req` in 1: exception/interrupt flush of the E-stage instruction this cycle.
- `op_valid` in 1: the E stage holds a real, unstalled instruction.
- `HILOOp` in 4: mult, multu, div, divu, mfhi, mflo, mthi, mtlo, or none.
- `RD1`, `RD2` in 32: forwarded rs/rt operands.
- `HILObusy` out 1: stall request to the hazard unit.
- `HILOout` out 32: mfhi/mflo read data; 0 for all other ops.
- `dp_start` out 1: one-cycle issue pulse to the datapath.
- `dp_op` out 2: `MD_OP_MULT`, `MD_OP_MULTU`, `MD_OP_DIV` or `MD_OP_DIVU`.
- `dp_a`, `dp_b` out 32: datapath operands.
- `dp_done` in 1: one-cycle completion pulse from the datapath.
- `dp_hi`, `dp_lo` in 32: datapath results, valid while `dp_done` is high.

## Operation
- FSM states:
  - IDLE: accepts an op.
  - RUN: waits for `dp_done`.
- The E-stage op is accepted only when `op_valid & !Req & state==IDLE`.
- Accepting a start op (mult/multu/div/divu):
  - Asserts `dp_start` combinationally, with `dp_a=RD1`, `dp_b=RD2` and `dp_op` decoded.
  - Moves the FSM to RUN.
  - Latches `dp_op` into `pend_op`.
- mthi/mtlo: write `RD1` to HI/LO at the clock edge.
- mfhi/mflo: `HILOout` is HI/LO combinationally, with no state change.
- RUN, on `dp_done`: HI<=`dp_hi`, LO<=`dp_lo`, then go to IDLE.
- `HILObusy = (accepted start op) | (state==RUN)`.
- `Req` in IDLE suppresses the E-stage op: no `dp_start`, no HI/LO write. The instruction is squashed.
- `Req` in RUN has no effect. The in-flight op is older than the faulting instruction and completes normally.
- A start op presented with `op_valid` in RUN is a protocol violation:
  - It is ignored.
  - A simulation-only assertion fires.
- `dp_done` in IDLE is ignored, for example a late completion after reset.
- `dp_a`/`dp_b`/`dp_op` are 0 whenever `dp_start` is low.

## Timing
- Reset values: state IDLE, HI=0, LO=0, `HILObusy`=0, `dp_start`=0, `dp_op`=0, `dp_a`=`dp_b`=0, `HILOout`=0.
- Issue cycle N: `dp_start`=1 and `HILObusy`=1 combinationally.
- Cycles N+1 .. done cycle D: `HILObusy`=1.
- HI/LO update at the edge ending cycle D. `HILObusy`=0 from D+1, and mfhi in D+1 returns the new value.
- Earliest completion: `dp_done` in N+1, giving total busy of 2 cycles.
- mthi followed by mfhi in the next cycle returns the written value. There is no same-cycle bypass.
- Reset asserted mid-RUN: immediately IDLE, HI/LO=0, busy drops asynchronously.

## Configuration
- `MD_CTRL_DIV0_FAST_EN` defined:
  - div/divu with `RD2==0` is not issued; `dp_start` stays 0.
  - HI<=`RD1` and LO<=32'hFFFFFFFF at the issue edge. The FSM stays IDLE.
  - `HILObusy` is high only in the issue cycle.
- Not defined: a zero divisor is issued to the datapath like any other divide.

## Structure
- Shared package/header holds:
  - The existing `HILO_*` op encodings.
  - New `MD_OP_*` 2-bit datapath op codes.
  - FSM state localparams `MD_IDLE`, `MD_RUN`.
- No sub-module: the FSM, the HI/LO registers and the decode are all in `md_ctrl`. The datapath is instantiated by the parent and connected through the `dp_*` ports.

## Test plan
- Reset low, then release; mfhi/mflo → `HILOout`=0, `HILObusy`=0.
- mult, RD1=32'hFFFFFFFE (-2), RD2=3; datapath model returns `dp_done` after 5 cycles with hi=32'hFFFFFFFF, lo=32'hFFFFFFFA → busy for 6 cycles; mfhi then mflo return those values.
- mthi 32'h12345678, then mfhi next cycle → 32'h12345678; no `dp_start` pulse.
- divu issued together with `Req`=1 → no `dp_start`, `HILObusy`=0 after that cycle, HI/LO unchanged.
- divu 7/2 issued; `Req` pulses in RUN; reset pulses low at cycle 3 of RUN; stale `dp_done` arrives later → HI=LO=0 and the FSM stays IDLE.
- div with RD2=0: with `MD_CTRL_DIV0_FAST_EN` → HI=RD1, LO=32'hFFFFFFFF, busy for 1 cycle, no `dp_start`. Without the macro → `dp_start`=1 and the FSM enters RUN.
